// File: rtl/timebase_min_sec.sv
// ---------------------------------------------------------------------------
// timebase_min_sec
//
// Seconds/minutes timebase for the wall clock. A free-running divider turns
// clk_in into a one-cycle tick per second; seconds (0-59) and minutes (0-59)
// count on that tick. Minute rollover 59->0 produces the hour event that feeds
// the 12-hour counter downstream. hr_clk_out is a registered, stretched copy of
// the hour event whose rising edge clocks that counter.
//
// Optional build macro: TIMEBASE_HR_SET_EN
//   Defined   -> adds hr_inc_in, a front-panel hour-set button that raises an
//                hour event without touching seconds or minutes.
//   Undefined -> hour events only come from minute rollover.
//
// Parameters:
//   TICK_DIV    system clock cycles per second (>= 2)
//   HR_CLK_HOLD number of second ticks hr_clk_out stays high (>= 1)
//
// Ports:
//   clk_in        system clock, rising edge
//   reset_in      synchronous reset, active-low
//   run_in        1 = divider and seconds advance, 0 = frozen
//   min_inc_in    debounced minute-set button; each rising edge adds a minute
//   sec_clr_in    level; holds divider and seconds at zero
//   hr_inc_in     (TIMEBASE_HR_SET_EN only) hour-set button
//   sec_count_out seconds, binary 0-59
//   min_count_out minutes, binary 0-59
//   sec_tick_out  one-cycle pulse per second
//   hr_tick_out   one-cycle pulse per hour event
//   hr_clk_out    registered hour clock for the downstream hour counter
// ---------------------------------------------------------------------------
module timebase_min_sec #(
    parameter int TICK_DIV    = 100000000,
    parameter int HR_CLK_HOLD = 1
) (
    input  logic       clk_in,
    input  logic       reset_in,
    input  logic       run_in,
    input  logic       min_inc_in,
    input  logic       sec_clr_in,
`ifdef TIMEBASE_HR_SET_EN
    input  logic       hr_inc_in,
`endif
    output logic [7:0] sec_count_out,
    output logic [7:0] min_count_out,
    output logic       sec_tick_out,
    output logic       hr_tick_out,
    output logic       hr_clk_out
);

    localparam int DIV_W  = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int HOLD_W = (HR_CLK_HOLD > 1) ? $clog2(HR_CLK_HOLD) : 1;

    localparam logic [DIV_W-1:0]  DIV_LAST  = DIV_W'(TICK_DIV - 1);
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HR_CLK_HOLD - 1);

    // Button inputs handled by the edge detector: bit 0 is always the
    // minute-set button, bit 1 (when built in) the hour-set button.
`ifdef TIMEBASE_HR_SET_EN
    localparam int NUM_SET = 2;
`else
    localparam int NUM_SET = 1;
`endif

    logic [DIV_W-1:0]   div_reg;
    logic [7:0]         sec_reg;
    logic [7:0]         min_reg;
    logic               sec_tick_reg;
    logic               hr_tick_reg;
    logic               hr_clk_reg;
    logic [HOLD_W-1:0]  hold_reg;
    logic [NUM_SET-1:0] set_cur_reg;
    logic [NUM_SET-1:0] set_prev_reg;

    logic [NUM_SET-1:0] set_raw;
    logic [NUM_SET-1:0] set_pulse;
    logic               tick;
    logic               carry;
    logic               min_adv;
    logic               nat_hr;
    logic               hr_event;

`ifdef TIMEBASE_HR_SET_EN
    assign set_raw = {hr_inc_in, min_inc_in};
`else
    assign set_raw = min_inc_in;
`endif

    // The buttons are registered once, then compared with their previous
    // registered value, so a set pulse appears one cycle after the input rises
    // and takes effect on the second edge.
    assign set_pulse = set_cur_reg & ~set_prev_reg;

    // A clear on the same edge suppresses the tick and therefore the carry.
    assign tick    = run_in && !sec_clr_in && (div_reg == DIV_LAST);
    assign carry   = tick && (sec_reg == 8'd59);
    // A carry and a set pulse on the same edge advance the minute only once.
    assign min_adv = carry || set_pulse[0];
    assign nat_hr  = carry && (min_reg == 8'd59);

`ifdef TIMEBASE_HR_SET_EN
    // A coincident hour-set merges into the natural event; a set request
    // while the hour clock is still high is dropped.
    assign hr_event = nat_hr || (set_pulse[1] && !hr_clk_reg);
`else
    assign hr_event = nat_hr;
`endif

    always_ff @(posedge clk_in) begin
        if (!reset_in) begin
            div_reg      <= '0;
            sec_reg      <= '0;
            min_reg      <= '0;
            sec_tick_reg <= 1'b0;
            hr_tick_reg  <= 1'b0;
            hr_clk_reg   <= 1'b0;
            hold_reg     <= '0;
            set_cur_reg  <= '0;
            set_prev_reg <= '0;
        end else begin
            set_cur_reg  <= set_raw;
            set_prev_reg <= set_cur_reg;

            if (sec_clr_in) begin
                div_reg <= '0;
            end else if (run_in) begin
                div_reg <= (div_reg == DIV_LAST) ? '0 : div_reg + 1'b1;
            end

            if (sec_clr_in) begin
                sec_reg <= '0;
            end else if (tick) begin
                sec_reg <= (sec_reg == 8'd59) ? 8'd0 : sec_reg + 8'd1;
            end

            if (min_adv) begin
                min_reg <= (min_reg == 8'd59) ? 8'd0 : min_reg + 8'd1;
            end

            sec_tick_reg <= tick;
            hr_tick_reg  <= hr_event;

            // hr_clk rises with the hour event and falls on the edge of the
            // HR_CLK_HOLD-th following second tick.
            if (hr_event) begin
                hr_clk_reg <= 1'b1;
                hold_reg   <= '0;
            end else if (hr_clk_reg && tick) begin
                if (hold_reg == HOLD_LAST) begin
                    hr_clk_reg <= 1'b0;
                    hold_reg   <= '0;
                end else begin
                    hold_reg <= hold_reg + 1'b1;
                end
            end
        end
    end

    assign sec_count_out = sec_reg;
    assign min_count_out = min_reg;
    assign sec_tick_out  = sec_tick_reg;
    assign hr_tick_out   = hr_tick_reg;
    assign hr_clk_out    = hr_clk_reg;

endmodule

// File: tb/tb_timebase_min_sec.sv
// Testbench for timebase_min_sec: directed scenarios plus randomized stimulus,
// all checked every cycle against a behavioural model of the timebase.
module tb_timebase_min_sec;

    localparam int TICK_DIV = 4;
    localparam int HOLD     = 1;

    logic       clk_in     = 1'b0;
    logic       reset_in   = 1'b0;
    logic       run_in     = 1'b0;
    logic       min_inc_in = 1'b0;
    logic       sec_clr_in = 1'b0;
`ifdef TIMEBASE_HR_SET_EN
    logic       hr_inc_in  = 1'b0;
`endif
    logic [7:0] sec_count_out;
    logic [7:0] min_count_out;
    logic       sec_tick_out;
    logic       hr_tick_out;
    logic       hr_clk_out;

    timebase_min_sec #(
        .TICK_DIV   (TICK_DIV),
        .HR_CLK_HOLD(HOLD)
    ) dut (
        .clk_in       (clk_in),
        .reset_in     (reset_in),
        .run_in       (run_in),
        .min_inc_in   (min_inc_in),
        .sec_clr_in   (sec_clr_in),
`ifdef TIMEBASE_HR_SET_EN
        .hr_inc_in    (hr_inc_in),
`endif
        .sec_count_out(sec_count_out),
        .min_count_out(min_count_out),
        .sec_tick_out (sec_tick_out),
        .hr_tick_out  (hr_tick_out),
        .hr_clk_out   (hr_clk_out)
    );

    always #5 clk_in = ~clk_in;

    int n_checks = 0;
    int n_fail   = 0;
    bit cmp_en   = 1'b0;
    int stick_seen = 0;
    int htick_seen = 0;

    task automatic check(input string name, input int actual, input int expected);
        n_checks++;
        if (actual != expected) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, actual, expected, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // Time since the last clear is kept as a plain count of running cycles;
    // seconds are the number of completed TICK_DIV periods, modulo 60.
    int m_run_cycles = 0;
    int m_sec_total  = 0;
    int m_min        = 0;
    int m_hold_ticks = 0;
    bit m_hclk       = 0;
    bit m_h1         = 0;   // min_inc_in as seen at the previous edge
    bit m_h2         = 0;   // min_inc_in as seen two edges ago
    int e_sec = 0, e_min = 0, e_stick = 0, e_htick = 0, e_hclk = 0;

    task automatic model_step();
        bit tick, setp, carry, hr;
        if (!reset_in) begin
            m_run_cycles = 0; m_sec_total = 0; m_min = 0; m_hold_ticks = 0;
            m_hclk = 0; m_h1 = 0; m_h2 = 0;
            e_sec = 0; e_min = 0; e_stick = 0; e_htick = 0; e_hclk = 0;
        end else begin
            tick  = run_in && !sec_clr_in && ((m_run_cycles % TICK_DIV) == TICK_DIV - 1);
            setp  = m_h1 && !m_h2;
            m_h2  = m_h1;
            m_h1  = min_inc_in;
            if (sec_clr_in)  m_run_cycles = 0;
            else if (run_in) m_run_cycles++;
            carry = 0;
            if (sec_clr_in) m_sec_total = 0;
            else if (tick) begin
                m_sec_total++;
                carry = ((m_sec_total % 60) == 0);
            end
            hr = carry && (m_min == 59);
            if (carry || setp) m_min = (m_min + 1) % 60;
            if (hr) begin
                m_hclk = 1; m_hold_ticks = 0;
            end else if (m_hclk && tick) begin
                m_hold_ticks++;
                if (m_hold_ticks == HOLD) m_hclk = 0;
            end
            e_sec = m_sec_total % 60; e_min = m_min; e_stick = tick;
            e_htick = hr; e_hclk = m_hclk;
        end
    endtask

    initial forever begin
        @(posedge clk_in);
        model_step();
    end

    // Compare process: outputs settle after the rising edge, sampled on the falling edge.
    initial forever begin
        @(negedge clk_in);
        if (cmp_en) begin
            check("model_sec",     int'(sec_count_out), e_sec);
            check("model_min",     int'(min_count_out), e_min);
            check("model_sec_tick", int'(sec_tick_out), e_stick);
            check("model_hr_tick", int'(hr_tick_out),   e_htick);
            check("model_hr_clk",  int'(hr_clk_out),    e_hclk);
            if (sec_tick_out) stick_seen++;
            if (hr_tick_out)  htick_seen++;
        end
    end

    task automatic pulse_min(input int n);
        repeat (n) begin
            min_inc_in = 1'b1;
            @(negedge clk_in);
            min_inc_in = 1'b0;
            @(negedge clk_in);
        end
    endtask

    task automatic do_reset();
        reset_in = 1'b0;
        @(negedge clk_in);
        reset_in = 1'b1;
    endtask

    // Wait (bounded) for hr_tick_out; returns cycles waited.
    task automatic wait_hr_tick(output int k);
        k = 0;
        while (!hr_tick_out && k < 400) begin
            @(negedge clk_in);
            k++;
        end
    endtask

    int k;

    initial begin
        // Reset then hold with run_in=0
        @(posedge clk_in);
        cmp_en = 1'b1;
        repeat (2) @(posedge clk_in);
        @(negedge clk_in);
        reset_in = 1'b1;
        repeat (20) @(negedge clk_in);
        check("hold_sec", int'(sec_count_out), 0);
        check("hold_min", int'(min_count_out), 0);
        check("hold_hr_clk", int'(hr_clk_out), 0);
        check("hold_no_ticks", stick_seen, 0);

        // Count/wrap: 240 running cycles from divider 0
        run_in = 1'b1;
        repeat (4) @(negedge clk_in);
        check("first_tick", int'(sec_tick_out), 1);
        check("first_sec", int'(sec_count_out), 1);
        repeat (236) @(negedge clk_in);
        check("wrap_sec", int'(sec_count_out), 0);
        check("wrap_min", int'(min_count_out), 1);
        check("wrap_tick", int'(sec_tick_out), 1);
        check("wrap_no_hr", htick_seen, 0);

        // Hour rollover
        run_in = 1'b0;
        do_reset();
        pulse_min(59);
        repeat (3) @(negedge clk_in);
        check("preset_min", int'(min_count_out), 59);
        run_in = 1'b1;
        wait_hr_tick(k);
        check("rollover_hr_tick", int'(hr_tick_out), 1);
        check("rollover_latency", k, 240);
        check("rollover_min", int'(min_count_out), 0);
        check("rollover_sec", int'(sec_count_out), 0);
        check("rollover_hr_clk", int'(hr_clk_out), 1);
        k = 0;
        while (hr_clk_out && k < 20) begin
            @(negedge clk_in);
            k++;
        end
        check("hr_clk_high_cycles", k, 4);
        check("hr_clk_fall_sec", int'(sec_count_out), 1);

        // Set wrap 59 -> 0 without an hour event
        run_in = 1'b0;
        pulse_min(59);
        repeat (3) @(negedge clk_in);
        check("setwrap_pre_min", int'(min_count_out), 59);
        min_inc_in = 1'b1;
        @(negedge clk_in);
        check("setwrap_e1_min", int'(min_count_out), 59);
        @(negedge clk_in);
        check("setwrap_e2_min", int'(min_count_out), 0);
        check("setwrap_no_hr", int'(hr_tick_out), 0);
        check("setwrap_sec", int'(sec_count_out), 1);
        min_inc_in = 1'b0;
        repeat (2) @(negedge clk_in);

        // Clear priority at sec=59, divider=TICK_DIV-1
        do_reset();
        pulse_min(5);
        repeat (3) @(negedge clk_in);
        run_in = 1'b1;
        repeat (239) @(negedge clk_in);
        check("clr_pre_sec", int'(sec_count_out), 59);
        sec_clr_in = 1'b1;
        @(negedge clk_in);
        check("clr_sec", int'(sec_count_out), 0);
        check("clr_no_tick", int'(sec_tick_out), 0);
        check("clr_min", int'(min_count_out), 5);
        sec_clr_in = 1'b0;
        repeat (4) @(negedge clk_in);
        check("clr_next_tick", int'(sec_tick_out), 1);
        check("clr_next_sec", int'(sec_count_out), 1);

        // Reset while hr_clk_out is high
        run_in = 1'b0;
        do_reset();
        pulse_min(59);
        repeat (3) @(negedge clk_in);
        run_in = 1'b1;
        wait_hr_tick(k);
        check("midrst_hr_clk_before", int'(hr_clk_out), 1);
        reset_in = 1'b0;
        @(negedge clk_in);
        check("midrst_hr_clk", int'(hr_clk_out), 0);
        check("midrst_hr_tick", int'(hr_tick_out), 0);
        check("midrst_sec", int'(sec_count_out), 0);
        check("midrst_min", int'(min_count_out), 0);
        check("midrst_sec_tick", int'(sec_tick_out), 0);
        reset_in = 1'b1;

        // Randomized stimulus against the model
        repeat (6000) begin
            run_in     = ($urandom % 8) != 0;
            min_inc_in = ($urandom % 3) == 0;
            sec_clr_in = ($urandom % 300) == 0;
            reset_in   = ($urandom % 1500) != 0;
            @(negedge clk_in);
        end
        reset_in = 1'b1;
        @(negedge clk_in);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
